// File: rtl/memwb_pipe_stage_pkg.sv
// Shared types for the MEM/WB pipeline stage: core width constants, payload
// struct, skid-buffer state enum and a saturating-increment helper.
package memwb_pipe_stage_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_REG_AW = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } memwb_state_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0]   alu_out;
    logic [CORE_XLEN-1:0]   mem_out;
    logic [CORE_REG_AW-1:0] rd;
    logic                   mem_to_reg;
    logic                   write_enable;
  } memwb_payload_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/memwb_pipe_stage_skid.sv
// pipe_skid_buffer: two-entry valid/ready skid buffer, generic over payload type T.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on out_ready_i.
module pipe_skid_buffer
  import memwb_pipe_stage_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  T             in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output T             out_data_o,
  output memwb_state_e state_o
);

  memwb_state_e state_q, state_d;
  T             main_q, main_d;
  T             skid_q, skid_d;
  logic         accept;
  logic         deliver;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign state_o     = state_q;

  assign accept  = in_valid_i && in_ready_o;
  assign deliver = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Payload registers keep stale contents; only the state is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_d = in_data_i;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: skid-buffered payload, qualified write strobe and write-back mux.
// Define MEMWB_PERF_EN to add the stall_cycles / retired performance counters.
module memwb_pipe_stage
  import memwb_pipe_stage_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int REG_AW = CORE_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_mem_out,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_mem_to_reg,
  input  logic              in_write_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_out,
  output logic [XLEN-1:0]   out_mem_out,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_mem_to_reg,
  output logic              out_write_enable,
  output logic [XLEN-1:0]   out_wb_data
`ifdef MEMWB_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       retired
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   mem_out;
    logic [REG_AW-1:0] rd;
    logic              mem_to_reg;
    logic              write_enable;
  } payload_t;

  payload_t     in_pl;
  payload_t     main_pl;
  memwb_state_e skid_state;

  assign in_pl.alu_out      = in_alu_out;
  assign in_pl.mem_out      = in_mem_out;
  assign in_pl.rd           = in_rd;
  assign in_pl.mem_to_reg   = in_mem_to_reg;
  assign in_pl.write_enable = in_write_enable;

  pipe_skid_buffer #(
    .T (payload_t)
  ) u_skid (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (main_pl),
    .state_o     (skid_state)
  );

  assign out_alu_out    = main_pl.alu_out;
  assign out_mem_out    = main_pl.mem_out;
  assign out_rd         = main_pl.rd;
  assign out_mem_to_reg = main_pl.mem_to_reg;
  assign out_wb_data    = main_pl.mem_to_reg ? main_pl.mem_out : main_pl.alu_out;

  // A stale main entry or a write to x0 must never reach the register file.
  assign out_write_enable = (skid_state != EMPTY) && main_pl.write_enable &&
                            (main_pl.rd != '0);

`ifdef MEMWB_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    stall_d   = sat_inc(stall_q, in_valid && !in_ready);
    retired_d = sat_inc(retired_q, out_valid && out_ready && out_write_enable);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      retired_q <= '0;
    end else begin
      stall_q   <= stall_d;
      retired_q <= retired_d;
    end
  end

  assign stall_cycles = stall_q;
  assign retired      = retired_q;
`endif

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Bench for memwb_pipe_stage: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations at the key points.
module tb_memwb_pipe_stage;
  import memwb_pipe_stage_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int PW     = $bits(memwb_payload_t);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_alu_out = '0;
  logic [XLEN-1:0]   in_mem_out = '0;
  logic [REG_AW-1:0] in_rd = '0;
  logic              in_mem_to_reg = 1'b0;
  logic              in_write_enable = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_alu_out;
  logic [XLEN-1:0]   out_mem_out;
  logic [REG_AW-1:0] out_rd;
  logic              out_mem_to_reg;
  logic              out_write_enable;
  logic [XLEN-1:0]   out_wb_data;
`ifdef MEMWB_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       retired;
`endif

  memwb_pipe_stage #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_out       (in_alu_out),
    .in_mem_out       (in_mem_out),
    .in_rd            (in_rd),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_write_enable  (in_write_enable),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_alu_out      (out_alu_out),
    .out_mem_out      (out_mem_out),
    .out_rd           (out_rd),
    .out_mem_to_reg   (out_mem_to_reg),
    .out_write_enable (out_write_enable),
    .out_wb_data      (out_wb_data)
`ifdef MEMWB_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .retired          (retired)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [31:0]   exp_stall = '0;
  logic [31:0]   exp_retired = '0;
  logic          run = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of at most two payloads.
  memwb_payload_t m_head;
  memwb_payload_t m_new;
  int             m_n;
  logic           m_acc;
  logic           m_del;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_stall   = '0;
      exp_retired = '0;
    end else begin
      m_n   = exp_q.size();
      m_acc = in_valid && (m_n < 2);
      m_del = (m_n != 0) && out_ready;
      if (in_valid && (m_n >= 2) && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
      if (m_del) begin
        m_head = memwb_payload_t'(exp_q[0]);
        if (m_head.write_enable && (m_head.rd != 0) && (exp_retired != 32'hFFFF_FFFF))
          exp_retired++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_del) void'(exp_q.pop_front());
        if (m_acc) begin
          m_new.alu_out      = in_alu_out;
          m_new.mem_out      = in_mem_out;
          m_new.rd           = in_rd;
          m_new.mem_to_reg   = in_mem_to_reg;
          m_new.write_enable = in_write_enable;
          exp_q.push_back(PW'(m_new));
        end
      end
    end
  end

  memwb_payload_t c_head;
  always @(negedge clk) begin
    if (run) begin
      chk("m_out_valid", out_valid, exp_q.size() != 0);
      chk("m_in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() != 0) begin
        c_head = memwb_payload_t'(exp_q[0]);
        chk("m_out_rd", out_rd, c_head.rd);
        chk("m_out_alu", out_alu_out, c_head.alu_out);
        chk("m_out_mem", out_mem_out, c_head.mem_out);
        chk("m_out_m2r", out_mem_to_reg, c_head.mem_to_reg);
        chk("m_wb_data", out_wb_data, c_head.mem_to_reg ? c_head.mem_out : c_head.alu_out);
        chk("m_out_we", out_write_enable, c_head.write_enable && (c_head.rd != 0));
      end else begin
        chk("m_out_we_empty", out_write_enable, 1'b0);
      end
`ifdef MEMWB_PERF_EN
      chk("m_stall_cycles", stall_cycles, exp_stall);
      chk("m_retired", retired, exp_retired);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] rd, input logic m2r, input logic we);
    in_valid        = v;
    in_alu_out      = alu;
    in_mem_out      = mem;
    in_rd           = rd;
    in_mem_to_reg   = m2r;
    in_write_enable = we;
  endtask

  task automatic idle();
    send(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mixed directed table: in_valid held high, out_ready toggles.
  logic [4:0]  tbl_rd   [8] = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
  logic [31:0] tbl_alu  [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
  logic [31:0] tbl_mem  [8] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8};
  logic        tbl_m2r  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        tbl_we   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        tbl_ordy [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // ---------------- directed sequence ----------------
  initial begin
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_data", out_wb_data, 32'h0);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_out_we", out_write_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Streaming with out_ready high.
    out_ready = 1'b1;
    send(1'b1, 32'h10, 32'h0, 5'd3, 1'b0, 1'b1);
    step();
    chk("stream0_valid", out_valid, 1'b1);
    chk("stream0_wb", out_wb_data, 32'h10);
    chk("stream0_ready", in_ready, 1'b1);
    send(1'b1, 32'h0, 32'hAB, 5'd4, 1'b1, 1'b1);
    step();
    chk("stream1_wb", out_wb_data, 32'hAB);
    chk("stream1_rd", out_rd, 5'd4);
    chk("stream1_ready", in_ready, 1'b1);
    idle();
    step();
    chk("stream_drained", out_valid, 1'b0);

    // Back-pressure: A, B accepted, C held off, then drained in order.
    out_ready = 1'b0;
    send(1'b1, 32'hA1, 32'h0, 5'd5, 1'b0, 1'b1);
    step();
    chk("bp_a_ready", in_ready, 1'b1);
    send(1'b1, 32'hB2, 32'h0, 5'd6, 1'b0, 1'b1);
    step();
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_a", out_rd, 5'd5);
    send(1'b1, 32'hC3, 32'h0, 5'd7, 1'b0, 1'b1);
    step();
    chk("bp_c_held", in_ready, 1'b0);
    chk("bp_still_a", out_wb_data, 32'hA1);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_rd, 5'd6);
    chk("bp_reopen", in_ready, 1'b1);
    step();
    chk("bp_head_c", out_wb_data, 32'hC3);
    idle();
    step();
    chk("bp_drained", out_valid, 1'b0);

    // x0 writes and stale main entry.
    send(1'b1, 32'h5, 32'h0, 5'd0, 1'b0, 1'b1);
    step();
    chk("x0_valid", out_valid, 1'b1);
    chk("x0_no_write", out_write_enable, 1'b0);
    send(1'b1, 32'h77, 32'h0, 5'd7, 1'b0, 1'b1);
    step();
    chk("r7_write", out_write_enable, 1'b1);
    idle();
    step();
    chk("stale_no_write", out_write_enable, 1'b0);

    // Flush in FULL together with an offered payload.
    out_ready = 1'b0;
    send(1'b1, 32'hD0, 32'h0, 5'd8, 1'b0, 1'b1);
    step();
    send(1'b1, 32'hE0, 32'h0, 5'd9, 1'b0, 1'b1);
    step();
    send(1'b1, 32'hF0, 32'h0, 5'd10, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_gone", out_valid, 1'b0);

    // Flush in ONE together with a delivery.
    send(1'b1, 32'h1B, 32'h0, 5'd11, 1'b0, 1'b1);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_one_valid", out_valid, 1'b0);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    send(1'b1, 32'hC0, 32'h0, 5'd12, 1'b0, 1'b1);
    step();
    send(1'b1, 32'hC1, 32'h0, 5'd13, 1'b0, 1'b1);
    step();
    idle();
    chk("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_wb", out_wb_data, 32'h0);
    chk("arst_rd", out_rd, 5'd0);
    chk("arst_we", out_write_enable, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Counter scenario: 7 delivered writes, then 5 stalled cycles.
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      send(1'b1, 32'h100 + i, 32'h0, 5'(i), 1'b0, 1'b1);
      step();
    end
    idle();
    step();
    out_ready = 1'b0;
    send(1'b1, 32'h200, 32'h0, 5'd20, 1'b0, 1'b0);
    repeat (7) step();
`ifdef MEMWB_PERF_EN
    chk("perf_stall", stall_cycles, 32'd5);
    chk("perf_retired", retired, 32'd7);
`endif
    idle();
    out_ready = 1'b1;
    repeat (3) step();

    // Mixed table.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, tbl_alu[i], tbl_mem[i], tbl_rd[i], tbl_m2r[i], tbl_we[i]);
      out_ready = tbl_ordy[i];
      step();
    end
    idle();
    out_ready = 1'b1;
    repeat (4) step();
    chk("table_drained", out_valid, 1'b0);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
